// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI pixel clock domain.
// Produces registered syncs, data enable, coordinates and strobes from free-running h/v counters.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_lock,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic          run
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          lock_meta;
    logic          active;
    logic          first_done;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          de_d;
    logic          hs_d;
    logic          vs_d;
    logic          ls_d;
    logic          fs_d;

    // Gating on both synchronizer stages lets the raster stop on the very edge run falls.
    assign active = run & lock_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            run       <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            run       <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!active) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        de_d = active && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_d = active && (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_d = active && (v_cnt >= VS_START) && (v_cnt < VS_END);
        ls_d = active && (h_cnt == '0);
        fs_d = ls_d && (v_cnt == '0);
    end

    // The first frame_start after a (re)start is not a completed frame, so it only arms first_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            first_done  <= 1'b0;
        end else begin
            de          <= de_d;
            hs          <= hs_d ? HS_POL : ~HS_POL;
            vs          <= vs_d ? VS_POL : ~VS_POL;
            pix_x       <= de_d ? h_cnt : '0;
            pix_y       <= de_d ? v_cnt : '0;
            line_start  <= ls_d;
            frame_start <= fs_d;
            first_done  <= active & (first_done | fs_d);
            if (fs_d && first_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized lock/reset stimulus on a small raster, checked against an arithmetic raster model.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 1;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int CW = 6;

    typedef struct packed {
        logic          run;
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [7:0]    fc;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic          pll_lock;
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;
    logic          run;

    int checks = 0;
    int failures = 0;

    obs_t exp_q[$];

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .hs(hs), .vs(vs), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t idle_obs(input logic [7:0] fc);
        obs_t o;
        o = '0;
        o.hs = ~HSP;
        o.vs = ~VSP;
        o.fc = fc;
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.run = run; o.hs = hs; o.vs = vs; o.de = de;
        o.ls = line_start; o.fs = frame_start;
        o.x = pix_x; o.y = pix_y; o.fc = frame_cnt;
        return o;
    endfunction

    task automatic check_output(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got run=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d fc=%0d required run=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d fc=%0d",
                     name, $time, got.run, got.hs, got.vs, got.de, got.ls, got.fs, got.x, got.y, got.fc,
                     want.run, want.hs, want.vs, want.de, want.ls, want.fs, want.x, want.y, want.fc);
        end
    endtask

    // Reference model: position is just the number of running edges folded onto the raster.
    bit   m_s1 = 1'b0, m_s2 = 1'b0, m_seen = 1'b0;
    int   m_k = 0;
    logic [7:0] m_fc = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        obs_t e;
        int h, v;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_seen = 1'b0; m_k = 0; m_fc = 8'd0;
            exp_q.delete();
        end else begin
            e = idle_obs(m_fc);
            if (m_s1 && m_s2) begin
                h = m_k % HT;
                v = (m_k / HT) % VT;
                e.de = (h < HA) && (v < VA);
                e.hs = (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP;
                e.vs = (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP;
                e.x  = e.de ? CW'(h) : '0;
                e.y  = e.de ? CW'(v) : '0;
                e.ls = (h == 0);
                e.fs = (h == 0) && (v == 0);
                if (e.fs) begin
                    if (m_seen) m_fc = m_fc + 8'd1;
                    m_seen = 1'b1;
                end
                e.fc = m_fc;
                m_k++;
            end else begin
                m_k = 0;
                m_seen = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = pll_lock;
            e.run = m_s2;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            check_output("raster", sample_dut(), exp_q.pop_front());
        end
    end

    task automatic apply_reset_pulse(input int hold);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_output("async_reset", sample_dut(), idle_obs(8'd0));
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input int kind);
        case (kind)
            0: begin
                repeat ($urandom_range(0, 150)) @(negedge clk);
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                pll_lock = 1'b1;
            end
            1: begin
                @(negedge clk) pll_lock = 1'b0;
                @(negedge clk) pll_lock = 1'b1;
            end
            2: begin
                @(negedge clk);
                #2 pll_lock = 1'b0;
                #2 pll_lock = 1'b1;
            end
            default: apply_reset_pulse($urandom_range(1, 5));
        endcase
        repeat ($urandom_range(20, 200)) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk) pll_lock = 1'b1;
        repeat (3 * HT * VT + 10) @(negedge clk);

        // Deterministic reset in the middle of vsync, then a restart with lock already high.
        apply_reset_pulse(3);
        repeat (3 + (VA + VF) * HT + 5) @(negedge clk);
        apply_reset_pulse(2);
        repeat (2 * HT * VT) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            apply_stimulus(int'($urandom_range(0, 3)));
        end
        repeat (HT * VT) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
